// File: rtl/cpu_mc_core.sv
// rtl/cpu_mc_core.sv - multi-cycle fetch/exec/mem CPU core on a req/ack memory port
// Optional illegal-opcode trap enabled by defining CPU_MC_TRAP_EN.
module cpu_mc_core #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic [ADDR_W-1:0] pc,
   output logic              halted,
   output logic              trap
);

   typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

   localparam logic [5:0] OP_NOP  = 6'd0;
   localparam logic [5:0] OP_ADD  = 6'd1;
   localparam logic [5:0] OP_SUB  = 6'd2;
   localparam logic [5:0] OP_AND  = 6'd3;
   localparam logic [5:0] OP_OR   = 6'd4;
   localparam logic [5:0] OP_XOR  = 6'd5;
   localparam logic [5:0] OP_LDI  = 6'd6;
   localparam logic [5:0] OP_ST   = 6'd7;
   localparam logic [5:0] OP_LD   = 6'd8;
   localparam logic [5:0] OP_JMP  = 6'd9;
   localparam logic [5:0] OP_BRF  = 6'd10;
   localparam logic [5:0] OP_HALT = 6'd63;

   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t            state;
   logic [31:0]       ir;
   logic [DATA_W-1:0] regs [8];
   logic [7:0]        flags;
   logic              trap_q;

   logic [5:0]        op;
   logic [2:0]        ra, rb, rd;
   logic              hl;
   logic [15:0]       imm;
   logic [DATA_W-1:0] a, b, d_old;
   logic [DATA_W:0]   sum, diff;
   logic [DATA_W-1:0] alu_res, ldi_hi;
   logic              alu_flag, wr_en, bad_op;
   logic [ADDR_W-1:0] pc_inc, pc_next, a_addr, imm_addr;

   assign op    = ir[5:0];
   assign ra    = ir[8:6];
   assign rb    = ir[11:9];
   assign rd    = ir[14:12];
   assign hl    = ir[15];
   assign imm   = ir[31:16];
   assign a     = regs[ra];
   assign b     = regs[rb];
   assign d_old = regs[rd];
   assign sum   = {1'b0, a} + {1'b0, b};
   assign diff  = {1'b0, a} - {1'b0, b};
   assign pc_inc = pc + ADDR_ONE;
   assign trap  = trap_q;

   // Register-sourced addresses truncate; branch immediates zero-extend.
   generate
      if (ADDR_W <= DATA_W) begin : g_a_trunc
         assign a_addr = a[ADDR_W-1:0];
      end else begin : g_a_ext
         assign a_addr = {{(ADDR_W-DATA_W){1'b0}}, a};
      end
      if (ADDR_W <= 16) begin : g_i_trunc
         assign imm_addr = imm[ADDR_W-1:0];
      end else begin : g_i_ext
         assign imm_addr = {{(ADDR_W-16){1'b0}}, imm};
      end
   endgenerate

`ifdef CPU_MC_TRAP_EN
   assign bad_op = (op > OP_BRF) && (op != OP_HALT);
`else
   assign bad_op = 1'b0;
`endif

   always_comb begin
      ldi_hi = d_old;
      ldi_hi[31:16] = imm;
   end

   always_comb begin
      alu_res  = '0;
      alu_flag = 1'b0;
      wr_en    = 1'b0;
      case (op)
         OP_ADD: begin
            {alu_flag, alu_res} = sum;
            wr_en = 1'b1;
         end
         OP_SUB: begin
            {alu_flag, alu_res} = diff;
            wr_en = 1'b1;
         end
         OP_AND: begin
            alu_res  = a & b;
            alu_flag = ~|(a & b);
            wr_en    = 1'b1;
         end
         OP_OR: begin
            alu_res  = a | b;
            alu_flag = ~|(a | b);
            wr_en    = 1'b1;
         end
         OP_XOR: begin
            alu_res  = a ^ b;
            alu_flag = ~|(a ^ b);
            wr_en    = 1'b1;
         end
         OP_LDI: begin
            alu_res  = hl ? ldi_hi : {{(DATA_W-16){1'b0}}, imm};
            alu_flag = hl ? ~|ldi_hi : ~|imm;
            wr_en    = 1'b1;
         end
         default: begin
            alu_res  = '0;
            alu_flag = 1'b0;
            wr_en    = 1'b0;
         end
      endcase
   end

   always_comb begin
      pc_next = pc;
      if (op == OP_JMP)
         pc_next = a_addr;
      else if ((op == OP_BRF) && flags[rb])
         pc_next = imm_addr;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_FETCH;
         pc        <= '0;
         ir        <= '0;
         flags     <= '0;
         for (int i = 0; i < 8; i++) regs[i] <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         halted    <= 1'b0;
         trap_q    <= 1'b0;
      end else begin
         case (state)
            S_FETCH: begin
               // First cycle after reset: request is raised here, not during reset.
               if (!mem_req) begin
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= pc;
               end else if (mem_ack) begin
                  ir      <= mem_rdata[31:0];
                  pc      <= pc_inc;
                  mem_req <= 1'b0;
                  state   <= S_EXEC;
               end
            end
            S_EXEC: begin
               if ((op == OP_LD) || (op == OP_ST)) begin
                  mem_req  <= 1'b1;
                  mem_we   <= (op == OP_ST);
                  mem_addr <= a_addr;
                  if (op == OP_ST) mem_wdata <= b;
                  state    <= S_MEM;
               end else if (op == OP_HALT) begin
                  halted <= 1'b1;
                  state  <= S_HALT;
               end else if (bad_op) begin
                  trap_q <= 1'b1;
                  halted <= 1'b1;
                  state  <= S_HALT;
               end else begin
                  if (wr_en) begin
                     regs[rd]  <= alu_res;
                     flags[rd] <= alu_flag;
                  end
                  pc       <= pc_next;
                  mem_addr <= pc_next;
                  mem_we   <= 1'b0;
                  mem_req  <= 1'b1;
                  state    <= S_FETCH;
               end
            end
            S_MEM: begin
               if (mem_ack) begin
                  if (!mem_we) regs[rd] <= mem_rdata;
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= pc;
                  state    <= S_FETCH;
               end
            end
            default: begin
               mem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_mc_core.sv
// tb/tb_cpu_mc_core.sv - directed self-checking bench for cpu_mc_core
module tb_cpu_mc_core;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_req, mem_we, mem_ack, halted, trap;
   logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
   logic [31:0] mem [0:255];
   int          wait_n;
   int          wcnt;
   int          st_cnt;
   logic        st_valid;
   logic [31:0] st_addr, st_data;
   logic        hold;
   logic [31:0] h_addr, h_wdata;
   logic        h_we;
   int          unstable;

   logic        req4, we4, ack4, halted4, trap4;
   logic [3:0]  addr4, pc4;
   logic [31:0] wd4, rd4;
   logic [31:0] mem4 [0:15];
   int          f0;

   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   cpu_mc_core #(.DATA_W(32), .ADDR_W(32)) dut (
      .clk(clk), .reset(rst_n), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ack(mem_ack), .pc(pc), .halted(halted), .trap(trap));

   cpu_mc_core #(.DATA_W(32), .ADDR_W(4)) dut4 (
      .clk(clk), .reset(rst_n), .mem_req(req4), .mem_we(we4),
      .mem_addr(addr4), .mem_wdata(wd4), .mem_rdata(rd4),
      .mem_ack(ack4), .pc(pc4), .halted(halted4), .trap(trap4));

   assign mem_ack   = mem_req && (wcnt == wait_n);
   assign mem_rdata = (st_valid && (mem_addr == st_addr)) ? st_data : mem[mem_addr[7:0]];
   assign ack4      = req4;
   assign rd4       = mem4[addr4];

   always @(posedge clk) begin
      if (!rst_n || !mem_req) wcnt <= 0;
      else if (mem_ack) wcnt <= 0;
      else wcnt <= wcnt + 1;
      if (!rst_n) begin
         st_cnt   <= 0;
         st_valid <= 1'b0;
      end else if (mem_req && mem_ack && mem_we) begin
         st_cnt   <= st_cnt + 1;
         st_valid <= 1'b1;
         st_addr  <= mem_addr;
         st_data  <= mem_wdata;
      end
   end

   // A pending request must keep address, direction and data until acked.
   initial unstable = 0;
   always @(posedge clk) begin
      if (hold && rst_n && (mem_req !== 1'b1 || mem_addr != h_addr ||
                            mem_we != h_we || mem_wdata != h_wdata))
         unstable <= unstable + 1;
      hold    <= rst_n && mem_req && !mem_ack;
      h_addr  <= mem_addr;
      h_we    <= mem_we;
      h_wdata <= mem_wdata;
   end

   always @(posedge clk) begin
      if (!rst_n) f0 <= 0;
      else if (req4 && ack4 && !we4 && addr4 == 4'd0) f0 <= f0 + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
   endtask

   function automatic logic [31:0] ins(input int op, input int ra, input int rb,
                                       input int rd, input int hl, input int imm);
      logic [31:0] w;
      w = {imm[15:0], hl[0], rd[2:0], rb[2:0], ra[2:0], op[5:0]};
      return w;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
   endtask

   // Cycles counted from release; the first edge only raises mem_req.
   task automatic run(output int cyc);
      @(negedge clk);
      rst_n = 1'b1;
      cyc = 0;
      while (!halted && cyc < 400) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   initial begin
      int          cyc;
      int          k;
      logic [31:0] acc;
      rst_n  = 1'b0;
      wait_n = 0;
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      for (int i = 0; i < 16; i++) mem4[i] = 32'h0;
      mem4[0]  = ins(10, 0, 1, 0, 0, 5);
      mem4[1]  = ins(6, 0, 0, 0, 0, 14);
      mem4[2]  = ins(9, 0, 0, 0, 0, 0);
      mem4[5]  = ins(63, 0, 0, 0, 0, 0);
      mem4[14] = ins(5, 1, 1, 1, 0, 0);
      mem4[15] = ins(0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", 32'(mem_req), 0);
      chk("rst_pc", pc, 0);
      chk("rst_halted", 32'(halted), 0);
      chk("rst_trap", 32'(trap), 0);
      chk("rst_we", 32'(mem_we), 0);
      chk("rst_wdata", mem_wdata, 0);

      // LDI r0,5; LDI r1,3; ADD r2,r0,r1; HALT
      do_reset();
      mem[0] = ins(6, 0, 0, 0, 0, 5);
      mem[1] = ins(6, 0, 0, 1, 0, 3);
      mem[2] = ins(1, 0, 1, 2, 0, 0);
      mem[3] = ins(63, 0, 0, 0, 0, 0);
      run(cyc);
      chk("p1_cycles", cyc, 9);
      chk("p1_halted", 32'(halted), 1);
      chk("p1_pc", pc, 4);
      chk("p1_r2", dut.regs[2], 8);
      chk("p1_f2", 32'(dut.flags[2]), 0);
      k = 0;
      while (!halted4 && k < 60) begin
         @(negedge clk);
         k++;
      end
      chk("a4_halted", 32'(halted4), 1);
      chk("a4_pc", 32'(pc4), 6);
      chk("a4_fetch0", f0, 2);

      // Carry, borrow, zero flags, rD==rA, BRF not-taken then taken
      do_reset();
      mem[0]    = ins(6, 0, 0, 0, 1, 16'hFFFF);
      mem[1]    = ins(6, 0, 0, 4, 0, 16'hFFFF);
      mem[2]    = ins(6, 0, 0, 4, 1, 16'hFFFF);
      mem[3]    = ins(6, 0, 0, 1, 0, 1);
      mem[4]    = ins(2, 1, 4, 6, 0, 0);
      mem[5]    = ins(5, 1, 1, 3, 0, 0);
      mem[6]    = ins(4, 6, 1, 2, 0, 0);
      mem[7]    = ins(1, 4, 1, 5, 0, 0);
      mem[8]    = ins(10, 0, 7, 0, 0, 16'h30);
      mem[9]    = ins(10, 0, 5, 0, 0, 16'h20);
      mem[8'h20] = ins(1, 6, 6, 6, 0, 0);
      mem[8'h21] = ins(63, 0, 0, 0, 0, 0);
      mem[8'h30] = ins(63, 0, 0, 0, 0, 0);
      run(cyc);
      chk("p2_r0_hl", dut.regs[0], 32'hFFFF0000);
      chk("p2_r4", dut.regs[4], 32'hFFFFFFFF);
      chk("p2_r5_add", dut.regs[5], 0);
      chk("p2_f5_carry", 32'(dut.flags[5]), 1);
      chk("p2_r3_xor", dut.regs[3], 0);
      chk("p2_f3_zero", 32'(dut.flags[3]), 1);
      chk("p2_r2_or", dut.regs[2], 3);
      chk("p2_f2", 32'(dut.flags[2]), 0);
      chk("p2_r6_dbl", dut.regs[6], 4);
      chk("p2_f6", 32'(dut.flags[6]), 0);
      chk("p2_pc_brf", pc, 32'h22);

      // SUB borrow is visible before r6 is overwritten at 0x20
      do_reset();
      mem[0] = ins(6, 0, 0, 1, 0, 1);
      mem[1] = ins(6, 0, 0, 4, 0, 2);
      mem[2] = ins(2, 1, 4, 6, 0, 0);
      mem[3] = ins(63, 0, 0, 0, 0, 0);
      run(cyc);
      chk("sub_res", dut.regs[6], 32'hFFFFFFFF);
      chk("sub_borrow", 32'(dut.flags[6]), 1);

      // ST/LD with 3 wait states per access
      do_reset();
      wait_n = 3;
      mem[0] = ins(6, 0, 0, 0, 0, 16'h10);
      mem[1] = ins(6, 0, 0, 1, 0, 16'hBEEF);
      mem[2] = ins(7, 0, 1, 0, 0, 0);
      mem[3] = ins(8, 0, 0, 3, 0, 0);
      mem[4] = ins(63, 0, 0, 0, 0, 0);
      run(cyc);
      chk("p3_cycles", cyc, 34);
      chk("p3_st_cnt", st_cnt, 1);
      chk("p3_st_addr", st_addr, 32'h10);
      chk("p3_st_data", st_data, 32'hBEEF);
      chk("p3_r3_ld", dut.regs[3], 32'hBEEF);
      chk("p3_pc", pc, 5);
      chk("p3_stable", unstable, 0);

      // Reset while a store sits in MEM
      do_reset();
      wait_n = 3;
      mem[0] = ins(6, 0, 0, 0, 0, 16'h10);
      mem[1] = ins(6, 0, 0, 2, 0, 9);
      mem[2] = ins(7, 0, 2, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      k = 0;
      while (!(mem_req && mem_we) && k < 100) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("mr_in_mem", 32'(mem_req && mem_we), 1);
      chk("mr_addr", mem_addr, 32'h10);
      chk("mr_wdata", mem_wdata, 9);
      rst_n = 1'b0;
      #1;
      chk("mr_req_drop", 32'(mem_req), 0);
      chk("mr_pc", pc, 0);
      acc = 32'(dut.flags);
      for (int i = 0; i < 8; i++) acc = acc | dut.regs[i];
      chk("mr_regs_zero", acc, 0);
      wait_n = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("mr_fetch_req", 32'(mem_req), 1);
      chk("mr_fetch_addr", mem_addr, 0);
      chk("mr_no_store", st_cnt, 0);

      // Undefined opcode 0x2A
      do_reset();
      mem[0] = ins(42, 0, 0, 1, 0, 16'h77);
      mem[1] = ins(6, 0, 0, 1, 0, 7);
      mem[2] = ins(63, 0, 0, 0, 0, 0);
      run(cyc);
`ifdef CPU_MC_TRAP_EN
      chk("ud_trap", 32'(trap), 1);
      chk("ud_halted", 32'(halted), 1);
      chk("ud_pc", pc, 1);
      chk("ud_r1", dut.regs[1], 0);
      repeat (3) @(posedge clk);
      #1;
      chk("ud_no_req", 32'(mem_req), 0);
`else
      chk("ud_trap", 32'(trap), 0);
      chk("ud_halted", 32'(halted), 1);
      chk("ud_pc", pc, 3);
      chk("ud_r1", dut.regs[1], 7);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
